// File: rtl/tree_pkg.sv
// Shared encodings for the tree command sequencer: op codes, FSM states, status codes.
package tree_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_INS  = 2'b01,
    OP_FIND = 2'b10,
    OP_DEL  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT,
    REPORT
  } state_e;

  localparam logic [7:0] ST_EMPTY = 8'hE0;
  localparam logic [7:0] ST_FULL  = 8'hE1;
  localparam logic [7:0] ST_MISS  = 8'hE2;
  localparam logic [7:0] ST_TMO   = 8'hEF;
  localparam logic [3:0] TAG_INS  = 4'hA;
  localparam logic [3:0] TAG_DEL  = 4'hD;

endpackage

// File: rtl/btn_edge.sv
// Button synchronizer plus rising-edge detect; a held button yields a single press pulse.
module btn_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/tree_cmd_ctrl.sv
// Button-driven command sequencer for the tree key store: arbitrate, guard, issue, wait, report.
module tree_cmd_ctrl import tree_pkg::*; #(
  parameter int KEY_W       = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              k0,
  input  logic              k1,
  input  logic              k2,
  input  logic [KEY_W-1:0]  sw,
  output logic [DATA_W-1:0] led,
  output logic              busy,
  output logic              err,
  output logic              tree_req,
  output logic [1:0]        tree_op,
  output logic [KEY_W-1:0]  tree_key,
  input  logic              tree_done,
  input  logic              tree_hit,
  input  logic [DATA_W-1:0] tree_rdata,
  input  logic              buf_full,
  input  logic              buf_empty
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  logic w_find, w_ins, w_del;
  op_e  w_op;

  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_k0 (.clk(clk), .rst(rst), .i_btn(k0), .o_pulse(w_find));
  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_k1 (.clk(clk), .rst(rst), .i_btn(k1), .o_pulse(w_ins));
  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_k2 (.clk(clk), .rst(rst), .i_btn(k2), .o_pulse(w_del));

  // Same-cycle presses: insert wins, then remove, then find.
  always_comb begin
    w_op = OP_NONE;
    if (w_ins)       w_op = OP_INS;
    else if (w_del)  w_op = OP_DEL;
    else if (w_find) w_op = OP_FIND;
  end

  state_e              r_st;
  op_e                 r_op;
  logic [KEY_W-1:0]    r_key;
  logic [DATA_W-1:0]   r_led;
  logic                r_busy, r_err, r_req;
  logic [CW-1:0]       r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st   <= IDLE;
      r_op   <= OP_NONE;
      r_key  <= '0;
      r_led  <= '0;
      r_busy <= 1'b0;
      r_err  <= 1'b0;
      r_req  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      case (r_st)
        IDLE: if (w_op != OP_NONE) begin
          r_key  <= sw;
          r_op   <= w_op;
          r_busy <= 1'b1;
          r_err  <= 1'b0;
          r_st   <= CHECK;
        end
        CHECK: begin
          if (r_op == OP_INS && buf_full) begin
            r_led <= DATA_W'(ST_FULL);
            r_err <= 1'b1;
            r_st  <= REPORT;
          end else if (r_op != OP_INS && buf_empty) begin
            r_led <= DATA_W'(ST_EMPTY);
            r_err <= 1'b1;
            r_st  <= REPORT;
          end else begin
            r_req <= 1'b1;
            r_st  <= ISSUE;
          end
        end
        ISSUE: begin
          r_req <= 1'b0;
          r_cnt <= '0;
          r_st  <= WAIT;
        end
        WAIT: begin
          if (tree_done) begin
            r_st <= REPORT;
            if (r_op == OP_INS) begin
              r_led <= DATA_W'({TAG_INS, r_key});
            end else if (!tree_hit) begin
              r_led <= DATA_W'(ST_MISS);
              r_err <= 1'b1;
            end else if (r_op == OP_FIND) begin
              r_led <= tree_rdata;
            end else begin
              r_led <= DATA_W'({TAG_DEL, r_key});
            end
          end else if (r_cnt == TMAX) begin
            r_led <= DATA_W'(ST_TMO);
            r_err <= 1'b1;
            r_st  <= REPORT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        REPORT: begin
          r_busy <= 1'b0;
          r_op   <= OP_NONE;
          r_st   <= IDLE;
        end
        default: r_st <= IDLE;
      endcase
    end
  end

  assign led      = r_led;
  assign busy     = r_busy;
  assign err      = r_err;
  assign tree_req = r_req;
  assign tree_op  = r_op;
  assign tree_key = r_key;

endmodule

// File: tb/tb_tree_cmd_ctrl.sv
// Directed bench for tree_cmd_ctrl with a simple fixed-latency tree responder.
module tb_tree_cmd_ctrl;

  logic       clk = 1'b0, rst = 1'b0;
  logic       k0 = 1'b0, k1 = 1'b0, k2 = 1'b0;
  logic [3:0] sw = '0;
  logic       tree_done = 1'b0, tree_hit = 1'b0;
  logic [7:0] tree_rdata = '0;
  logic       buf_full = 1'b0, buf_empty = 1'b0;
  logic [7:0] led;
  logic       busy, err, tree_req;
  logic [1:0] tree_op;
  logic [3:0] tree_key;

  int vec = 0, bad = 0, total_req = 0;

  always #5 clk = ~clk;

  tree_cmd_ctrl #(.KEY_W(4), .DATA_W(8), .TIMEOUT(64), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .k0(k0), .k1(k1), .k2(k2), .sw(sw),
    .led(led), .busy(busy), .err(err), .tree_req(tree_req), .tree_op(tree_op),
    .tree_key(tree_key), .tree_done(tree_done), .tree_hit(tree_hit),
    .tree_rdata(tree_rdata), .buf_full(buf_full), .buf_empty(buf_empty)
  );

  always @(negedge clk) if (tree_req) total_req++;

  // Press buttons, answer any tree_req three cycles later (if rsp), return once busy falls.
  task automatic run_cmd(input logic [2:0] btn, input logic [3:0] key, input bit rsp,
                         input bit hit, input logic [7:0] rd, input bit late_k0,
                         output int nreq, output logic [1:0] cop, output logic [3:0] ckey,
                         output bit fin);
    int  since;
    bit  seen, wb;
    nreq = 0; cop = '0; ckey = '0; fin = 0; seen = 0; wb = 0; since = 0;
    @(negedge clk);
    sw = key;
    {k2, k1, k0} = btn;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge clk);
      tree_done = 1'b0;
      if (tree_req) begin
        nreq++; cop = tree_op; ckey = tree_key; seen = 1; since = 0;
        if (late_k0) k0 = 1'b1;
      end else if (seen) begin
        since++;
      end
      if (rsp && seen && since == 3) begin
        tree_done = 1'b1; tree_hit = hit; tree_rdata = rd;
      end
      if (busy) wb = 1;
      else if (wb) fin = 1;
    end
    tree_done = 1'b0;
    {k2, k1, k0} = 3'b000;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    vec++; if ({led, busy, err, tree_req, tree_op, tree_key} !== '0) begin
      bad++; $display("FAIL por_outputs got led=%h busy=%b err=%b req=%b op=%b key=%h exp all 0",
                      led, busy, err, tree_req, tree_op, tree_key);
    end
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_insert(input logic [3:0] key, input logic [7:0] exp_led);
    int n; logic [1:0] op; logic [3:0] kk; bit fin;
    run_cmd(3'b010, key, 1, 0, 8'h00, 0, n, op, kk, fin);
    vec++; if (!fin || n !== 1 || op !== 2'b01 || kk !== key) begin
      bad++; $display("FAIL ins_issue fin=%0b nreq=%0d op=%b key=%h exp fin=1 nreq=1 op=01 key=%h",
                      fin, n, op, kk, key);
    end
    vec++; if (led !== exp_led || err !== 1'b0) begin
      bad++; $display("FAIL ins_led got led=%h err=%b exp led=%h err=0", led, err, exp_led);
    end
  endtask

  task automatic test_find;
    int n; logic [1:0] op; logic [3:0] kk; bit fin;
    run_cmd(3'b001, 4'h3, 1, 1, 8'h33, 0, n, op, kk, fin);
    vec++; if (n !== 1 || op !== 2'b10 || kk !== 4'h3) begin
      bad++; $display("FAIL find_issue nreq=%0d op=%b key=%h exp 1 10 3", n, op, kk);
    end
    vec++; if (led !== 8'h33 || err !== 1'b0) begin
      bad++; $display("FAIL find_hit got led=%h err=%b exp 33 0", led, err);
    end
    run_cmd(3'b001, 4'h5, 1, 0, 8'h55, 0, n, op, kk, fin);
    vec++; if (led !== 8'hE2 || err !== 1'b1) begin
      bad++; $display("FAIL find_miss got led=%h err=%b exp E2 1", led, err);
    end
  endtask

  task automatic test_remove;
    int n; logic [1:0] op; logic [3:0] kk; bit fin;
    run_cmd(3'b100, 4'h6, 1, 1, 8'h00, 0, n, op, kk, fin);
    vec++; if (n !== 1 || op !== 2'b11 || led !== 8'hD6 || err !== 1'b0) begin
      bad++; $display("FAIL del_hit nreq=%0d op=%b led=%h err=%b exp 1 11 D6 0", n, op, led, err);
    end
  endtask

  task automatic test_guards;
    int n; logic [1:0] op; logic [3:0] kk; bit fin;
    buf_full = 1'b1;
    run_cmd(3'b010, 4'h2, 1, 0, 8'h00, 0, n, op, kk, fin);
    vec++; if (!fin || n !== 0 || led !== 8'hE1 || err !== 1'b1) begin
      bad++; $display("FAIL guard_full fin=%0b nreq=%0d led=%h err=%b exp 1 0 E1 1", fin, n, led, err);
    end
    buf_full = 1'b0; buf_empty = 1'b1;
    run_cmd(3'b100, 4'h2, 1, 1, 8'h00, 0, n, op, kk, fin);
    vec++; if (n !== 0 || led !== 8'hE0 || err !== 1'b1) begin
      bad++; $display("FAIL guard_empty_del nreq=%0d led=%h err=%b exp 0 E0 1", n, led, err);
    end
    run_cmd(3'b001, 4'h2, 1, 1, 8'h00, 0, n, op, kk, fin);
    vec++; if (n !== 0 || led !== 8'hE0 || busy !== 1'b0) begin
      bad++; $display("FAIL guard_empty_find nreq=%0d led=%h busy=%b exp 0 E0 0", n, led, busy);
    end
    buf_empty = 1'b0;
  endtask

  task automatic test_back_to_back;
    int n, base; logic [1:0] op; logic [3:0] kk; bit fin;
    run_cmd(3'b111, 4'h4, 1, 1, 8'h77, 0, n, op, kk, fin);
    vec++; if (n !== 1 || op !== 2'b01 || led !== 8'hA4) begin
      bad++; $display("FAIL simul_arb nreq=%0d op=%b led=%h exp 1 01 A4", n, op, led);
    end
    base = total_req;
    run_cmd(3'b010, 4'h9, 1, 0, 8'h00, 1, n, op, kk, fin);
    repeat (20) @(negedge clk);
    vec++; if (total_req - base !== 1 || led !== 8'hA9 || busy !== 1'b0) begin
      bad++; $display("FAIL busy_drop reqs=%0d led=%h busy=%b exp 1 A9 0", total_req - base, led, busy);
    end
  endtask

  task automatic test_timeout;
    int n; logic [1:0] op; logic [3:0] kk; bit fin;
    run_cmd(3'b010, 4'h2, 0, 0, 8'h00, 0, n, op, kk, fin);
    vec++; if (!fin || n !== 1 || led !== 8'hEF || err !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL timeout fin=%0b nreq=%0d led=%h err=%b busy=%b exp 1 1 EF 1 0",
                      fin, n, led, err, busy);
    end
    run_cmd(3'b010, 4'h3, 1, 0, 8'h00, 0, n, op, kk, fin);
    vec++; if (n !== 1 || led !== 8'hA3 || err !== 1'b0) begin
      bad++; $display("FAIL after_tmo nreq=%0d led=%h err=%b exp 1 A3 0", n, led, err);
    end
  endtask

  task automatic test_reset_midwait;
    int base; bit seen;
    seen = 0;
    @(negedge clk); sw = 4'h7; k1 = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (tree_req) seen = 1;
    end
    vec++; if (!seen) begin
      bad++; $display("FAIL rst_setup tree_req not seen within 20 cycles");
    end
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b0; k1 = 1'b0;
    #1;
    vec++; if ({led, busy, err, tree_req, tree_op, tree_key} !== '0) begin
      bad++; $display("FAIL rst_midwait got led=%h busy=%b err=%b req=%b op=%b key=%h exp all 0",
                      led, busy, err, tree_req, tree_op, tree_key);
    end
    @(negedge clk); rst = 1'b1;
    base = total_req;
    tree_done = 1'b1; tree_hit = 1'b1;
    @(negedge clk); tree_done = 1'b0;
    repeat (80) @(negedge clk);
    vec++; if (total_req !== base || busy !== 1'b0 || led !== 8'h00) begin
      bad++; $display("FAIL rst_quiet reqs=%0d busy=%b led=%h exp 0 0 00", total_req - base, busy, led);
    end
  endtask

  initial begin
    test_reset;
    test_insert(4'h1, 8'hA1);
    test_insert(4'hA, 8'hAA);
    test_insert(4'h8, 8'hA8);
    test_find;
    test_remove;
    test_guards;
    test_back_to_back;
    test_timeout;
    test_reset_midwait;
    test_insert(4'h5, 8'hA5);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
